// File: rtl/line_pop_ctrl.sv
// Line-buffer window pop/flush sequencer: pops WIN_SIZE lines as a window, then retires the oldest line.
// Optional READ watchdog enabled by defining LINE_POP_CTRL_TIMEOUT_EN.
module line_pop_ctrl #(
    parameter int BUF_CNT  = 4,
    parameter int WIN_SIZE = 3,
    parameter int TIMEOUT  = 4096
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       sof_i,
    input  logic [BUF_CNT-1:0]         unread_i,
    input  logic [BUF_CNT-1:0]         empty_i,
    input  logic                       out_rdy_i,
    input  logic                       eol_i,
    output logic [BUF_CNT-1:0]         pop_line_o,
    output logic [BUF_CNT-1:0]         flush_line_o,
    output logic [$clog2(BUF_CNT)-1:0] base_o,
    output logic                       busy_o,
    output logic                       timeout_o
);
    // state | meaning
    // IDLE  | waiting for every window buffer to hold an unread line and the consumer to be ready
    // READ  | window popped, consumer streaming lines out; waits for end of line
    // FLUSH | oldest line retired, base advanced; back to IDLE next cycle

    localparam int BW = $clog2(BUF_CNT);
    localparam logic [BUF_CNT-1:0] LOW_MASK = BUF_CNT'((1 << WIN_SIZE) - 1);

    if (WIN_SIZE < 1 || WIN_SIZE > BUF_CNT - 1) begin : g_bad_win
        $error("line_pop_ctrl: WIN_SIZE must be in 1..BUF_CNT-1");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("line_pop_ctrl: TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t               state;
    logic [2*BUF_CNT-1:0] rot_dbl;
    logic [BUF_CNT-1:0]   win_mask;
    logic                 win_ok;
    logic [BW-1:0]        base_next;

    // Rotate the low WIN_SIZE-bit mask left by base, wrapping at BUF_CNT.
    always_comb begin
        rot_dbl  = {LOW_MASK, LOW_MASK} << base_o;
        win_mask = rot_dbl[2*BUF_CNT-1:BUF_CNT];
        win_ok   = ((unread_i & win_mask) == win_mask) &&
                   ((empty_i & win_mask) == '0) && out_rdy_i;
        base_next = (base_o == BW'(BUF_CNT - 1)) ? '0 : base_o + BW'(1);
    end

    assign busy_o = (state != IDLE);

`ifdef LINE_POP_CTRL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            base_o       <= '0;
            pop_line_o   <= '0;
            flush_line_o <= '0;
            timeout_o    <= 1'b0;
            wd_cnt       <= '0;
        end else begin
            pop_line_o   <= '0;
            flush_line_o <= '0;
            if (sof_i) begin
                state     <= IDLE;
                base_o    <= '0;
                timeout_o <= 1'b0;
                wd_cnt    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (win_ok) begin
                            pop_line_o <= win_mask;
                            wd_cnt     <= WD_W'(TIMEOUT - 1);
                            state      <= READ;
                        end
                    end
                    READ: begin
                        if (eol_i || wd_cnt == '0) begin
                            flush_line_o <= BUF_CNT'(1) << base_o;
                            base_o       <= base_next;
                            state        <= FLUSH;
                            if (!eol_i) timeout_o <= 1'b1;
                        end else begin
                            wd_cnt <= wd_cnt - WD_W'(1);
                        end
                    end
                    FLUSH:   state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
`else
    assign timeout_o = 1'b0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            base_o       <= '0;
            pop_line_o   <= '0;
            flush_line_o <= '0;
        end else begin
            pop_line_o   <= '0;
            flush_line_o <= '0;
            if (sof_i) begin
                state  <= IDLE;
                base_o <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (win_ok) begin
                            pop_line_o <= win_mask;
                            state      <= READ;
                        end
                    end
                    READ: begin
                        if (eol_i) begin
                            flush_line_o <= BUF_CNT'(1) << base_o;
                            base_o       <= base_next;
                            state        <= FLUSH;
                        end
                    end
                    FLUSH:   state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
`endif

endmodule
